// File: rtl/mems_pkg.sv
// Shared MEMS mirror-driver definitions: DAC word width, DAC command words
// and the serial-link state encoding.
package mems_pkg;

  localparam int DAC_WORD_W = 24;

  localparam logic [DAC_WORD_W-1:0] DAC_CMD_SOFT_RESET = 24'h280001;
  localparam logic [DAC_WORD_W-1:0] DAC_CMD_EXT_REF    = 24'h380000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } dac_state_e;

endpackage

// File: rtl/mems_dac_spi_if.sv
// Request/status handshake between mems_control (master) and the DAC
// serial link (slave).
interface mems_dac_spi_if
  import mems_pkg::*;
#(
  parameter int WORD_W = DAC_WORD_W
);
  logic              start;
  logic [WORD_W-1:0] data_in;
  logic              busy;
  logic              done;

  modport master (output start, data_in, input busy, done);
  modport slave  (input start, data_in, output busy, done);
endinterface

// File: rtl/spi_phase_tick.sv
// Divider for the SPI link: one-cycle tick every CLK_DIV clk cycles,
// restarted by clear so a new frame always begins with a full phase.
module spi_phase_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);
  localparam int CNT_W = $clog2(CLK_DIV + 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick = (cnt_q == CNT_W'(CLK_DIV - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end
endmodule

// File: rtl/mems_dac_spi.sv
// Serialises one DAC command word per start request: SCLK idles high, the DAC
// samples MOSI on falling edges, SYNC_N frames the word plus a hold period.
module mems_dac_spi
  import mems_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 2,
  parameter int WORD_W     = DAC_WORD_W
) (
  input  logic            clk,
  input  logic            rst,
  mems_dac_spi_if.slave   bus,
  output logic            sclk,
  output logic            sync_n,
  output logic            mosi
);
  localparam int BIT_W = $clog2(WORD_W + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  dac_state_e        state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              sclk_q, sclk_d;
  logic              sync_n_q, sync_n_d;
  logic              mosi_q, mosi_d;
  logic              start_accept;
  logic              phase_tick;

  assign start_accept = (state_q == ST_IDLE) && bus.start;

  spi_phase_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_phase_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(start_accept),
    .tick (phase_tick)
  );

  // NOTE: every signal gets its hold value first, so no path through the
  // case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    sclk_d    = sclk_q;
    sync_n_d  = sync_n_q;
    mosi_d    = mosi_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d   = ST_SHIFT;
          shreg_d   = bus.data_in;
          bit_cnt_d = '0;
          busy_d    = 1'b1;
          sync_n_d  = 1'b0;
          sclk_d    = 1'b1;
          mosi_d    = bus.data_in[WORD_W-1];
        end
      end
      ST_SHIFT: begin
        if (phase_tick) begin
          if (sclk_q) begin
            sclk_d = 1'b0;
          end else if (bit_cnt_q == BIT_W'(WORD_W - 1)) begin
            sclk_d  = 1'b1;
            mosi_d  = 1'b0;
            state_d = ST_HOLD;
          end else begin
            // Rising SCLK presents the next lower bit for a full high phase.
            sclk_d    = 1'b1;
            shreg_d   = shreg_q << 1;
            mosi_d    = shreg_d[WORD_W-1];
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      ST_HOLD: begin
        if (phase_tick) begin
          sync_n_d  = 1'b1;
          gap_cnt_d = '0;
          state_d   = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sclk_q    <= 1'b1;
      sync_n_q  <= 1'b1;
      mosi_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sclk_q    <= sclk_d;
      sync_n_q  <= sync_n_d;
      mosi_q    <= mosi_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign sclk     = sclk_q;
  assign sync_n   = sync_n_q;
  assign mosi     = mosi_q;
endmodule
